// File: rtl/apb_requester.sv
// apb_requester: valid/ready request/response to APB3/APB4 requester, one transfer at a time,
// with a per-transfer ACCESS timeout so a silent completer cannot hang the core side.
module apb_requester #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [2:0]        req_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] out_paddr,
  output logic              out_psel,
  output logic              out_penable,
  output logic [2:0]        out_pprot,
  output logic              out_pwrite,
  output logic [DATA_W-1:0] out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic              out_pready,
  input  logic [DATA_W-1:0] out_prdata,
  input  logic              out_pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic expire;
  // Abort on the ACCESS edge that would be the TIMEOUT-th wait, giving TIMEOUT penable cycles.
  assign expire = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  assign req_ready = (state == IDLE) && !reset;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_valid ? SETUP : IDLE;
      SETUP:   state_n = ACCESS;
      ACCESS:  state_n = (out_pready || expire) ? RESP : ACCESS;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      out_paddr   <= '0;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      out_pprot   <= '0;
      out_pwrite  <= 1'b0;
      out_pwdata  <= '0;
      out_pstrb   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (req_valid) begin
          out_paddr  <= req_addr;
          out_pwrite <= req_write;
          out_pprot  <= req_prot;
          out_pwdata <= req_write ? req_wdata : '0;
          out_pstrb  <= req_write ? req_wstrb : '0;
          out_psel   <= 1'b1;
        end
        SETUP: begin
          out_penable <= 1'b1;
          cnt         <= '0;
        end
        ACCESS: if (out_pready || expire) begin
          rsp_rdata   <= (out_pready && !out_pwrite) ? out_prdata : '0;
          rsp_err     <= out_pready ? out_pslverr : 1'b1;
          rsp_valid   <= 1'b1;
          out_psel    <= 1'b0;
          out_penable <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed checks of apb_requester; instances 0/1/2 use TIMEOUT 255/4/0
// and share every input, so the timeout variants are exercised by the same stimulus.
module tb_apb_requester;
  logic clock, reset;
  logic req_valid, req_write, rsp_ready, out_pready, out_pslverr;
  logic [31:0] req_addr, req_wdata, out_prdata;
  logic [3:0] req_wstrb;
  logic [2:0] req_prot;
  logic [2:0] req_ready, rsp_valid, rsp_err, psel, penable, pwrite;
  logic [31:0] rsp_rdata [3];
  logic [31:0] paddr [3];
  logic [31:0] pwdata [3];
  logic [2:0] pprot [3];
  logic [3:0] pstrb [3];
  int checks = 0, errors = 0;
  int n0, n1, n2;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_requester #(.TIMEOUT(g == 0 ? 255 : g == 1 ? 4 : 0)) u_dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready[g]), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
      .out_paddr(paddr[g]), .out_psel(psel[g]), .out_penable(penable[g]), .out_pprot(pprot[g]),
      .out_pwrite(pwrite[g]), .out_pwdata(pwdata[g]), .out_pstrb(pstrb[g]),
      .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic request(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d; req_wstrb = s; req_prot = 3'b010;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid drops after handshake", rsp_valid[0], 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
    out_pready = 1'b1; out_pslverr = 1'b0; req_addr = '0; req_wdata = '0;
    out_prdata = '0; req_wstrb = '0; req_prot = '0;
    tick(); tick();
    check("reset req_ready", req_ready, 3'b000);
    check("reset psel", psel, 3'b000);
    check("reset rsp_valid", rsp_valid, 3'b000);
    check("reset paddr", paddr[0], 32'h0);
    reset = 1'b0;
    tick();
    check("idle req_ready", req_ready, 3'b111);
    // zero-wait write
    request(32'h1000_0004, 1'b1, 32'hA5A5_A5A5, 4'hF);
    check("w0 setup psel", psel[0], 1'b1);
    check("w0 setup penable", penable[0], 1'b0);
    check("w0 req_ready busy", req_ready[0], 1'b0);
    check("w0 paddr", paddr[0], 32'h1000_0004);
    check("w0 pwrite", pwrite[0], 1'b1);
    check("w0 pstrb", pstrb[0], 4'hF);
    check("w0 pwdata", pwdata[0], 32'hA5A5_A5A5);
    check("w0 pprot", pprot[0], 3'b010);
    tick();
    check("w0 access psel", psel[0], 1'b1);
    check("w0 access penable", penable[0], 1'b1);
    tick();
    check("w0 done psel", psel[0], 1'b0);
    check("w0 done penable", penable[0], 1'b0);
    check("w0 rsp_valid", rsp_valid[0], 1'b1);
    check("w0 rsp_err", rsp_err[0], 1'b0);
    check("w0 rsp_rdata", rsp_rdata[0], 32'h0);
    handshake();
    check("w0 idle req_ready", req_ready[0], 1'b1);
    // write with one wait state
    out_pready = 1'b0;
    request(32'h1000_0008, 1'b1, 32'h1234_5678, 4'h3);
    tick();
    check("w1 penable cycle1", penable[0], 1'b1);
    tick();
    check("w1 penable cycle2", penable[0], 1'b1);
    check("w1 paddr stable", paddr[0], 32'h1000_0008);
    check("w1 pwdata stable", pwdata[0], 32'h1234_5678);
    check("w1 pstrb", pstrb[0], 4'h3);
    check("w1 no rsp yet", rsp_valid[0], 1'b0);
    out_pready = 1'b1;
    tick();
    check("w1 penable drop", penable[0], 1'b0);
    check("w1 rsp_valid", rsp_valid[0], 1'b1);
    check("w1 rsp_err", rsp_err[0], 1'b0);
    handshake();
    // read with 3 waits and pslverr; TIMEOUT=4 instance hits its limit on the same edge
    out_pready = 1'b0;
    out_prdata = 32'h5555_5555; out_pslverr = 1'b1;
    request(32'h0000_0020, 1'b0, 32'hFFFF_FFFF, 4'hF);
    check("r0 pwrite", pwrite[0], 1'b0);
    check("r0 pstrb zero", pstrb[0], 4'h0);
    check("r0 pwdata zero", pwdata[0], 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r0 penable waiting", penable[0], 1'b1);
    end
    out_pready = 1'b1; out_prdata = 32'hDEAD_BEEF;
    tick();
    out_pready = 1'b0; out_prdata = 32'h0; out_pslverr = 1'b0;
    check("r0 rsp_valid", rsp_valid, 3'b111);
    check("r0 rsp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
    check("r0 rsp_err", rsp_err[0], 1'b1);
    check("r0 pready beats timeout", rsp_rdata[1], 32'hDEAD_BEEF);
    // back-pressure with a second request waiting
    req_valid = 1'b1; req_addr = 32'h44; req_write = 1'b1; req_wdata = 32'h0F0F_0F0F; req_wstrb = 4'h1;
    out_pready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp rsp_valid", rsp_valid[0], 1'b1);
      check("bp rsp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
      check("bp rsp_err", rsp_err[0], 1'b1);
      check("bp req_ready", req_ready[0], 1'b0);
      check("bp psel", psel[0], 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp handshake rsp_valid", rsp_valid[0], 1'b0);
    check("bp no early accept", psel[0], 1'b0);
    check("bp req_ready back", req_ready[0], 1'b1);
    tick();
    req_valid = 1'b0;
    check("bp second accepted", psel[0], 1'b1);
    check("bp second paddr", paddr[0], 32'h44);
    tick(); tick();
    check("bp second rsp", rsp_valid[0], 1'b1);
    check("bp second err", rsp_err[0], 1'b0);
    handshake();
    // completer never ready
    out_pready = 1'b0; out_prdata = 32'hCAFE_F00D;
    request(32'h30, 1'b0, 32'h0, 4'h0);
    tick();
    n0 = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < 1000; i++) begin
      n0 += int'(penable[0]); n1 += int'(penable[1]); n2 += int'(penable[2]);
      tick();
    end
    check("to4 penable cycles", n1, 4);
    check("to255 penable cycles", n0, 255);
    check("to0 penable cycles", n2, 1000);
    check("to4 psel", psel[1], 1'b0);
    check("to4 rsp_valid", rsp_valid[1], 1'b1);
    check("to4 rsp_err", rsp_err[1], 1'b1);
    check("to4 rsp_rdata", rsp_rdata[1], 32'h0);
    check("to255 rsp_err", rsp_err[0], 1'b1);
    check("to0 still waiting", {psel[2], penable[2], rsp_valid[2]}, 3'b110);
    // reset while instance 2 is in ACCESS
    reset = 1'b1;
    tick();
    check("rst psel", psel, 3'b000);
    check("rst penable", penable, 3'b000);
    check("rst rsp_valid", rsp_valid, 3'b000);
    check("rst req_ready", req_ready, 3'b000);
    reset = 1'b0;
    #1;
    check("post-rst req_ready", req_ready, 3'b111);
    tick();
    check("post-rst no rsp", rsp_valid, 3'b000);
    out_pready = 1'b1; out_prdata = 32'h0BAD_F00D;
    request(32'h40, 1'b0, 32'h0, 4'h0);
    tick(); tick();
    check("post-rst rsp_valid", rsp_valid, 3'b111);
    check("post-rst rdata", rsp_rdata[2], 32'h0BAD_F00D);
    check("post-rst err", rsp_err, 3'b000);
    handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
